// File: rtl/pea_pkg.sv
// Shared constants for the polynomial evaluation accelerator.
// Modes, opcodes, command fields and status bits.
package pea_pkg;

  localparam logic [1:0] SETUP_INSTR = 2'b00;
  localparam logic [1:0] INSTR       = 2'b01;

  localparam logic [7:0] OP_STP = 8'd0;
  localparam logic [7:0] OP_EVP = 8'd1;
  localparam logic [7:0] OP_EVB = 8'd2;
  localparam logic [7:0] OP_RST = 8'd3;

  localparam int MODE_LSB = 0;
  localparam int MODE_MSB = 7;
  localparam int ARG1_LSB = 8;
  localparam int ARG1_MSB = 10;
  localparam int ARG2_LSB = 11;
  localparam int ARG2_MSB = 15;

  localparam int ST_OVF   = 0;
  localparam int ST_UNDEF = 1;

  function automatic int pea_log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/pea_coeff_mem.sv
// Coefficient register file for all polynomial slots.
// One sync write, one comb read, per-slot valid and degree.
module pea_coeff_mem
  import pea_pkg::*;
#(
  parameter int W  = 16,
  parameter int NP = 8,
  parameter int MC = 16,
  parameter int PW = 3,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [PW-1:0] poly,
  input  logic          we,
  input  logic [CW-1:0] widx,
  input  logic [W-1:0]  wdata,
  input  logic          set_en,
  input  logic          set_valid,
  input  logic [CW-1:0] set_deg,
  input  logic [CW-1:0] ridx,
  output logic [W-1:0]  rdata,
  output logic          valid,
  output logic [CW-1:0] deg
);

  logic [W-1:0]  mem [NP][MC];
  logic [NP-1:0] vld;
  logic [CW-1:0] dg [NP];

  // Coefficient storage is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (we) mem[poly][widx] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      dg  <= '{default: '0};
    end else if (set_en) begin
      vld[poly] <= set_valid;
      dg[poly]  <= set_deg;
    end
  end

  assign rdata = mem[poly][ridx];
  assign valid = vld[poly];
  assign deg   = dg[poly];

endmodule

// File: rtl/pea_core_fsm.sv
// PEA firing engine: fetch/decode, coefficient store,
// Horner evaluation and result/status emission.
module pea_core_fsm
  import pea_pkg::*;
#(
  parameter int word_size   = 16,
  parameter int buffer_size = 1024,
  parameter int NUM_POLY    = 8,
  parameter int MAX_COEFF   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 invoke,
  output logic                 FC,
  output logic [1:0]           next_mode_out,
  output logic [7:0]           mode_out,
  output logic [4:0]           arg2_out,
  output logic                 cmd_rd_en,
  input  logic [word_size-1:0] cmd_data,
  output logic                 data_rd_en,
  input  logic [word_size-1:0] data_in,
  output logic                 result_wr_en,
  output logic [word_size-1:0] result_out,
  output logic                 status_wr_en,
  output logic [word_size-1:0] status_out
);

  localparam int W  = word_size;
  localparam int PW = pea_log2(NUM_POLY);
  localparam int CW = pea_log2(MAX_COEFF);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, STP_RD, X_RD,
    X_LOAD, HORNER, OUT_WR, DONE
  } state_t;

  state_t        state;
  logic [PW-1:0] arg1_q;
  logic          rd_q;
  logic [5:0]    cnt;
  logic [5:0]    wcnt;
  logic [CW-1:0] idx;
  logic [W-1:0]  x_q;
  logic [W-1:0]  acc;
  logic          ovf;

  logic          mem_we;
  logic          set_en;
  logic          set_valid;
  logic [CW-1:0] set_deg;
  logic [CW-1:0] ridx;
  logic [W-1:0]  c_rd;
  logic          p_valid;
  logic [CW-1:0] p_deg;
  logic          is_stp;
  logic          is_evp;
  logic          is_evb;
  logic          is_rst;
  logic          op_go;
  logic [2*W-1:0] acc_x;
  logic [2*W-1:0] x_x;
  logic [2*W-1:0] prod;
  logic [2*W:0]   sum;
  logic           ovf_n;

  pea_coeff_mem #(
    .W(W), .NP(NUM_POLY), .MC(MAX_COEFF),
    .PW(PW), .CW(CW)
  ) u_mem (
    .clk(clk),
    .rst(rst),
    .poly(arg1_q),
    .we(mem_we),
    .widx(wcnt[CW-1:0]),
    .wdata(data_in),
    .set_en(set_en),
    .set_valid(set_valid),
    .set_deg(set_deg),
    .ridx(ridx),
    .rdata(c_rd),
    .valid(p_valid),
    .deg(p_deg)
  );

  always_comb begin
    is_stp = mode_out == OP_STP;
    is_evp = mode_out == OP_EVP;
    is_evb = mode_out == OP_EVB;
    is_rst = mode_out == OP_RST;
    op_go  = (state == IDLE) && invoke
             && (next_mode_out == INSTR);
    mem_we = (state == STP_RD) && rd_q
             && (wcnt < 6'(MAX_COEFF));
    set_en    = op_go && (is_stp || is_rst);
    set_valid = is_stp && (arg2_out != '0);
    set_deg   = (arg2_out >= 5'(MAX_COEFF))
              ? CW'(MAX_COEFF - 1)
              : CW'(arg2_out - 5'd1);
    ridx  = (state == X_LOAD) ? p_deg : idx;
    // Full-precision signed step; overflow if either
    // the product or the sum leaves the word range.
    acc_x = {{W{acc[W-1]}}, acc};
    x_x   = {{W{x_q[W-1]}}, x_q};
    prod  = acc_x * x_x;
    sum   = {prod[2*W-1], prod}
          + {{(W+1){c_rd[W-1]}}, c_rd};
    ovf_n = ovf
          | (prod[2*W-1:W-1] != {(W+1){prod[W-1]}})
          | (sum[2*W:W-1] != {(W+2){sum[W-1]}});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      FC            <= 1'b0;
      next_mode_out <= SETUP_INSTR;
      mode_out      <= '0;
      arg2_out      <= '0;
      cmd_rd_en     <= 1'b0;
      data_rd_en    <= 1'b0;
      result_wr_en  <= 1'b0;
      result_out    <= '0;
      status_wr_en  <= 1'b0;
      status_out    <= '0;
      arg1_q        <= '0;
      rd_q          <= 1'b0;
      cnt           <= '0;
      wcnt          <= '0;
      idx           <= '0;
      x_q           <= '0;
      acc           <= '0;
      ovf           <= 1'b0;
    end else begin
      FC           <= 1'b0;
      cmd_rd_en    <= 1'b0;
      data_rd_en   <= 1'b0;
      result_wr_en <= 1'b0;
      status_wr_en <= 1'b0;
      rd_q         <= data_rd_en;
      unique case (state)
        IDLE: begin
          if (invoke && next_mode_out == SETUP_INSTR) begin
            cmd_rd_en <= 1'b1;
            state     <= FETCH;
          end else if (op_go) begin
            unique case (1'b1)
              (is_stp && arg2_out != '0): begin
                data_rd_en <= 1'b1;
                cnt        <= 6'd1;
                wcnt       <= '0;
                state      <= STP_RD;
              end
              (is_evp || (is_evb && arg2_out != '0)): begin
                data_rd_en <= 1'b1;
                cnt        <= is_evb ? 6'(arg2_out) : 6'd1;
                state      <= X_RD;
              end
              default: begin
                FC            <= 1'b1;
                next_mode_out <= SETUP_INSTR;
                state         <= DONE;
              end
            endcase
          end
        end
        FETCH: state <= DECODE;
        DECODE: begin
          mode_out <= cmd_data[MODE_MSB:MODE_LSB];
          arg1_q   <= cmd_data[ARG1_MSB:ARG1_LSB];
          arg2_out <= cmd_data[ARG2_MSB:ARG2_LSB];
          next_mode_out <= (cmd_data[MODE_MSB:MODE_LSB] <= OP_RST)
                         ? INSTR : SETUP_INSTR;
          FC    <= 1'b1;
          state <= DONE;
        end
        STP_RD: begin
          if (cnt < 6'(arg2_out)) begin
            data_rd_en <= 1'b1;
            cnt        <= cnt + 6'd1;
          end
          if (rd_q) begin
            wcnt <= wcnt + 6'd1;
            if (wcnt == 6'(arg2_out) - 6'd1) begin
              FC            <= 1'b1;
              next_mode_out <= SETUP_INSTR;
              state         <= DONE;
            end
          end
        end
        X_RD: state <= X_LOAD;
        X_LOAD: begin
          x_q <= data_in;
          ovf <= 1'b0;
          if (!p_valid) begin
            result_out   <= '0;
            status_out   <= W'(1) << ST_UNDEF;
            result_wr_en <= 1'b1;
            status_wr_en <= 1'b1;
            state        <= OUT_WR;
          end else if (p_deg == '0) begin
            result_out   <= c_rd;
            status_out   <= '0;
            result_wr_en <= 1'b1;
            status_wr_en <= 1'b1;
            state        <= OUT_WR;
          end else begin
            acc   <= c_rd;
            idx   <= p_deg - CW'(1);
            state <= HORNER;
          end
        end
        HORNER: begin
          acc <= sum[W-1:0];
          ovf <= ovf_n;
          if (idx == '0) begin
            result_out   <= sum[W-1:0];
            status_out   <= W'(ovf_n) << ST_OVF;
            result_wr_en <= 1'b1;
            status_wr_en <= 1'b1;
            state        <= OUT_WR;
          end else begin
            idx <= idx - CW'(1);
          end
        end
        OUT_WR: begin
          if (cnt > 6'd1) begin
            cnt        <= cnt - 6'd1;
            data_rd_en <= 1'b1;
            state      <= X_RD;
          end else begin
            FC            <= 1'b1;
            next_mode_out <= SETUP_INSTR;
            state         <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pea_core_fsm.sv
// Bench for pea_core_fsm: FIFO models plus a polynomial
// reference model driven by directed and random firings.
module tb_pea_core_fsm;
  import pea_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        invoke;
  logic        FC;
  logic [1:0]  next_mode_out;
  logic [7:0]  mode_out;
  logic [4:0]  arg2_out;
  logic        cmd_rd_en;
  logic [15:0] cmd_data;
  logic        data_rd_en;
  logic [15:0] data_in;
  logic        result_wr_en;
  logic [15:0] result_out;
  logic        status_wr_en;
  logic [15:0] status_out;

  pea_core_fsm dut (
    .clk(clk),
    .rst(rst),
    .invoke(invoke),
    .FC(FC),
    .next_mode_out(next_mode_out),
    .mode_out(mode_out),
    .arg2_out(arg2_out),
    .cmd_rd_en(cmd_rd_en),
    .cmd_data(cmd_data),
    .data_rd_en(data_rd_en),
    .data_in(data_in),
    .result_wr_en(result_wr_en),
    .result_out(result_out),
    .status_wr_en(status_wr_en),
    .status_out(status_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [15:0] cmd_q[$];
  logic [15:0] dat_q[$];
  logic [15:0] res_q[$];
  logic [15:0] sts_q[$];
  int pops = 0;
  int underflow = 0;

  always @(posedge clk) begin
    if (cmd_rd_en) begin
      if (cmd_q.size() > 0) cmd_data <= cmd_q.pop_front();
      else underflow++;
    end
    if (data_rd_en) begin
      pops++;
      if (dat_q.size() > 0) data_in <= dat_q.pop_front();
      else underflow++;
    end
    if (result_wr_en) res_q.push_back(result_out);
    if (status_wr_en) sts_q.push_back(status_out);
  end

  logic [15:0] mcoef [8][16];
  bit          mvalid [8];
  int          mdeg [8];
  logic [15:0] dv [32];

  function automatic logic [15:0] mk(int op, int p, int a2);
    logic [15:0] w;
    w[7:0]   = op[7:0];
    w[10:8]  = p[2:0];
    w[15:11] = a2[4:0];
    return w;
  endfunction

  function automatic void eval(int p, logic [15:0] x,
                               output logic [15:0] r,
                               output logic [15:0] s);
    longint acc, xv, pr, sm;
    logic [15:0] t;
    bit ov;
    ov = 0;
    if (!mvalid[p]) begin
      r = 16'h0000;
      s = 16'h0002;
      return;
    end
    xv  = longint'($signed(x));
    acc = longint'($signed(mcoef[p][mdeg[p]]));
    for (int i = mdeg[p] - 1; i >= 0; i--) begin
      pr = acc * xv;
      sm = pr + longint'($signed(mcoef[p][i]));
      if (pr > 32767 || pr < -32768) ov = 1;
      if (sm > 32767 || sm < -32768) ov = 1;
      t   = sm[15:0];
      acc = longint'($signed(t));
    end
    r = acc[15:0];
    s = {15'd0, ov};
  endfunction

  task automatic fire(output int fc_at, output int rd_at);
    fc_at = -1;
    rd_at = -1;
    @(negedge clk);
    invoke = 1'b1;
    for (int k = 1; k <= 1000; k++) begin
      @(negedge clk);
      invoke = 1'b0;
      if (cmd_rd_en && rd_at < 0) rd_at = k;
      if (FC) begin
        fc_at = k;
        break;
      end
    end
    if (fc_at < 0) check("fc_timeout", FC, 1);
  endtask

  task automatic run(int op, int p, int a2);
    int fa, ra, np, ep;
    logic [15:0] r, s;
    logic [15:0] er[$];
    logic [15:0] es[$];
    cmd_q.push_back(mk(op, p, a2));
    fire(fa, ra);
    check("setup_rd", ra, 1);
    check("setup_fc", fa, 3);
    check("setup_nm", next_mode_out, (op <= 3) ? 1 : 0);
    if (op > 3) return;
    check("mode", mode_out, op);
    check("arg2", arg2_out, a2);
    ep = 0;
    if (op == 0) begin
      ep = a2;
      for (int k = 0; k < a2; k++)
        if (k < 16) mcoef[p][k] = dv[k];
      mvalid[p] = (a2 != 0);
      if (a2 != 0) mdeg[p] = ((a2 > 16) ? 16 : a2) - 1;
    end else if (op == 1 || op == 2) begin
      ep = (op == 1) ? 1 : a2;
      for (int i = 0; i < ep; i++) begin
        eval(p, dv[i], r, s);
        er.push_back(r);
        es.push_back(s);
      end
    end else begin
      mvalid[p] = 0;
    end
    for (int i = 0; i < ep; i++) dat_q.push_back(dv[i]);
    res_q.delete();
    sts_q.delete();
    np = pops;
    fire(fa, ra);
    if (op == 3) check("rst_fc", fa, 1);
    check("instr_nm", next_mode_out, 0);
    check("pops", pops - np, ep);
    check("n_res", res_q.size(), er.size());
    check("n_sts", sts_q.size(), es.size());
    for (int i = 0; i < er.size(); i++) begin
      if (i < res_q.size()) check("res", res_q[i], er[i]);
      if (i < sts_q.size()) check("sts", sts_q[i], es[i]);
    end
  endtask

  initial begin
    int fa, ra;
    rst      = 1'b1;
    invoke   = 1'b0;
    cmd_data = '0;
    data_in  = '0;
    for (int i = 0; i < 8; i++) begin
      mvalid[i] = 0;
      mdeg[i]   = 0;
    end
    repeat (3) @(negedge clk);
    check("rst_fc", FC, 0);
    check("rst_nm", next_mode_out, 0);
    check("rst_mode", mode_out, 0);
    check("rst_arg2", arg2_out, 0);
    check("rst_strobes",
          {cmd_rd_en, data_rd_en, result_wr_en, status_wr_en}, 0);
    check("rst_res", result_out, 0);
    check("rst_sts", status_out, 0);
    rst = 1'b0;

    // 0x1A00: STP poly 2, coefficients 3,2,1
    check("cmd_word", mk(0, 2, 3), 16'h1A00);
    dv[0] = 16'd3; dv[1] = 16'd2; dv[2] = 16'd1;
    run(0, 2, 3);

    dv[0] = 16'd2;
    run(1, 2, 0);
    check("evp_11", res_q[0], 16'd11);
    check("evp_11_st", sts_q[0], 16'h0000);

    dv[0] = 16'd0; dv[1] = 16'd1; dv[2] = 16'hFFFF;
    run(2, 2, 3);
    check("evb_0", res_q[0], 16'd3);
    check("evb_1", res_q[1], 16'd6);
    check("evb_m1", res_q[2], 16'd2);

    run(2, 2, 0);

    dv[0] = 16'd9;
    run(1, 5, 0);
    check("undef5_st", sts_q[0], 16'h0002);
    run(3, 2, 0);
    dv[0] = 16'd7;
    run(1, 2, 0);
    check("undef2_res", res_q[0], 16'h0000);
    check("undef2_st", sts_q[0], 16'h0002);

    dv[0] = 16'h0000; dv[1] = 16'h4000;
    run(0, 0, 2);
    dv[0] = 16'd4;
    run(1, 0, 0);
    check("ovf_res", res_q[0], 16'h0000);
    check("ovf_st", sts_q[0], 16'h0001);

    // More words than slots: extras are popped and dropped
    for (int k = 0; k < 18; k++) dv[k] = 16'(k + 1);
    run(0, 3, 18);
    dv[0] = 16'd1;
    run(1, 3, 0);
    check("sum16", res_q[0], 16'd136);

    run(0, 4, 0);
    run(7, 1, 2);

    for (int n = 0; n < 60; n++) begin
      int sel, op, p, a2;
      sel = $urandom_range(0, 9);
      p   = $urandom_range(0, 7);
      a2  = 0;
      if (sel <= 2) begin
        op = 0;
        a2 = $urandom_range(0, 18);
      end else if (sel <= 5) begin
        op = 1;
      end else if (sel <= 7) begin
        op = 2;
        a2 = $urandom_range(0, 4);
      end else if (sel == 8) begin
        op = 3;
      end else begin
        op = $urandom_range(4, 255);
        a2 = $urandom_range(0, 31);
      end
      for (int k = 0; k < 32; k++) begin
        if (op == 0 && $urandom_range(0, 3) == 0)
          dv[k] = 16'($urandom);
        else
          dv[k] = 16'($urandom_range(0, 6)) - 16'd3;
      end
      run(op, p, a2);
    end

    // Abort an evaluation in the middle of Horner steps
    for (int k = 0; k < 16; k++) dv[k] = 16'($urandom_range(0, 3));
    run(0, 1, 16);
    cmd_q.push_back(mk(1, 1, 0));
    fire(fa, ra);
    dat_q.push_back(16'd1);
    @(negedge clk);
    invoke = 1'b1;
    @(negedge clk);
    invoke = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_strobes",
          {cmd_rd_en, data_rd_en, result_wr_en, status_wr_en}, 0);
    check("abort_fc", FC, 0);
    check("abort_nm", next_mode_out, 0);
    @(negedge clk);
    rst = 1'b0;
    dat_q.delete();
    for (int i = 0; i < 8; i++) mvalid[i] = 0;
    dv[0] = 16'd5;
    run(1, 1, 0);
    check("abort_undef", sts_q[0], 16'h0002);

    check("underflow", underflow, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
